vector_fx_mult_sub: RTL and testbench



---
 rtl/vector_fx_mult_sub.sv | 94 +++++++++
 tb/tb_vector_fx_mult_sub.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_fx_mult_sub.sv
// vector_fx_mult_sub: N-lane 3-stage signed fixed-point out = in0*b - c with round-half-up and saturation.
// Define VMS_SAT_FLAG_EN to add the per-lane out_sat clamp flags.
module vector_fx_mult_sub #(
    parameter int bitwidth = 16,
    parameter int N        = 8,
    parameter int FRAC     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N*bitwidth-1:0] in0,
    input  logic [N*bitwidth-1:0] in1,
    input  logic [N*bitwidth-1:0] in2,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [N*bitwidth-1:0] out,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
`ifdef VMS_SAT_FLAG_EN
    ,
    output logic [N-1:0]          out_sat
`endif
);
    localparam int W  = bitwidth;
    localparam int PW = 2 * W;
    localparam int DW = 2 * W + 2;
    localparam logic signed [DW-1:0] RND  = DW'((1 << FRAC) >> 1);
    localparam logic signed [DW-1:0] SMAX = {{(DW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = ~SMAX;

    logic                 w_ce;
    logic signed [W-1:0]  r1_a [N];
    logic signed [W-1:0]  r1_b [N];
    logic signed [W-1:0]  r1_c [N];
    logic                 r1_v, r1_last;
    logic signed [PW-1:0] r2_p [N];
    logic signed [W-1:0]  r2_c [N];
    logic                 r2_v, r2_last;
    logic signed [W-1:0]  w_res [N];
    logic [N-1:0]         w_sat;

    assign w_ce     = !out_valid || out_ready;
    assign in_ready = w_ce;

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic signed [DW-1:0] w_d, w_r;
        assign w_d      = DW'(r2_p[g]) - (DW'(r2_c[g]) <<< FRAC) + RND;
        assign w_r      = w_d >>> FRAC;
        assign w_sat[g] = (w_r > SMAX) || (w_r < SMIN);
        assign w_res[g] = w_sat[g] ? (w_r[DW-1] ? W'(SMIN) : W'(SMAX)) : W'(w_r);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r1_v      <= 1'b0;
            r1_last   <= 1'b0;
            r2_v      <= 1'b0;
            r2_last   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef VMS_SAT_FLAG_EN
            out_sat   <= '0;
`endif
            for (int k = 0; k < N; k++) begin
                r1_a[k] <= '0;
                r1_b[k] <= '0;
                r1_c[k] <= '0;
                r2_p[k] <= '0;
                r2_c[k] <= '0;
            end
        end else if (w_ce) begin
            r1_v      <= in_valid;
            r1_last   <= in_last;
            r2_v      <= r1_v;
            r2_last   <= r1_last;
            out_valid <= r2_v;
            out_last  <= r2_last;
`ifdef VMS_SAT_FLAG_EN
            out_sat   <= w_sat;
`endif
            for (int k = 0; k < N; k++) begin
                r1_a[k]          <= in0[k*W +: W];
                r1_b[k]          <= in_bcast ? in1[W-1:0] : in1[k*W +: W];
                r1_c[k]          <= in_bcast ? in2[W-1:0] : in2[k*W +: W];
                r2_p[k]          <= PW'(r1_a[k]) * PW'(r1_b[k]);
                r2_c[k]          <= r1_c[k];
                out[k*W +: W]    <= w_res[k];
            end
        end
    end
endmodule

// File: tb/tb_vector_fx_mult_sub.sv
// tb_vector_fx_mult_sub: randomized self-checking bench with an integer-arithmetic reference model.
module tb_vector_fx_mult_sub;
    localparam int W = 16, N = 8, FRAC = 8, NW = N * W;

    logic          clk = 0, rstn = 0;
    logic [NW-1:0] in0 = '0, in1 = '0, in2 = '0;
    logic          in_bcast = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic          in_ready, out_valid, out_last;
    logic [NW-1:0] out;
`ifdef VMS_SAT_FLAG_EN
    logic [N-1:0]  out_sat;
`endif

    vector_fx_mult_sub #(.bitwidth(W), .N(N), .FRAC(FRAC)) dut (
        .clk(clk), .rstn(rstn), .in0(in0), .in1(in1), .in2(in2),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
`ifdef VMS_SAT_FLAG_EN
        , .out_sat(out_sat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] d;
        logic          l;
        logic [N-1:0]  s;
        int            t;
    } beat_t;

    int    total = 0, bad = 0, cyc = 0;
    beat_t exp_q[$], got_q[$];

    function automatic logic [NW-1:0] model(input logic [NW-1:0] a, b, c, input logic bc,
                                            output logic [N-1:0] s);
        longint av, bv, cv, r, one;
        logic [NW-1:0] o;
        o = '0; s = '0; one = longint'(1) <<< FRAC;
        for (int i = 0; i < N; i++) begin
            av = longint'($signed(a[i*W +: W]));
            bv = bc ? longint'($signed(b[W-1:0])) : longint'($signed(b[i*W +: W]));
            cv = bc ? longint'($signed(c[W-1:0])) : longint'($signed(c[i*W +: W]));
            r  = (av * bv - cv * one + one / 2) >>> FRAC;
            if (r > 32767) begin r = 32767; s[i] = 1'b1; end
            else if (r < -32768) begin r = -32768; s[i] = 1'b1; end
            o[i*W +: W] = r[W-1:0];
        end
        return o;
    endfunction

    function automatic logic [NW-1:0] rvec();
        logic [NW-1:0] v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 7))
                0: v[i*W +: W] = 16'h7FFF;
                1: v[i*W +: W] = 16'h8000;
                default: v[i*W +: W] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        beat_t e, g;
        logic [N-1:0] s;
        if (rstn && in_valid && in_ready) begin
            e.d = model(in0, in1, in2, in_bcast, s);
`ifdef VMS_SAT_FLAG_EN
            e.s = s;
`else
            e.s = '0;
`endif
            e.l = in_last; e.t = cyc;
            exp_q.push_back(e);
        end
        if (rstn && out_valid && out_ready) begin
            g.d = out; g.l = out_last; g.t = cyc;
`ifdef VMS_SAT_FLAG_EN
            g.s = out_sat;
`else
            g.s = '0;
`endif
            got_q.push_back(g);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    task automatic send(input logic [NW-1:0] a, b, c, input logic bc, l);
        bit ok;
        int n;
        in0 = a; in1 = b; in2 = c; in_bcast = bc; in_last = l; in_valid = 1; n = 0;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 200);
        in_valid = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL send_accept got=0 required=1"); end
    endtask

    task automatic wait_drain(input int n, output bit ok);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (got_q.size() >= n) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
        if (out !== '0) begin bad++; $display("FAIL rst_out got=%h required=0", out); end
        if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b required=0", out_last); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
`ifdef VMS_SAT_FLAG_EN
        total++;
        if (out_sat !== '0) begin bad++; $display("FAIL rst_out_sat got=%b required=0", out_sat); end
`endif
        rstn = 1; out_ready = 1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid got=%b required=0", out_valid); end
    endtask

    task automatic test_basic;
        logic [NW-1:0] b, c;
        bit ok;
        exp_q.delete(); got_q.delete();
        b = rvec(); c = rvec();
        b[W-1:0] = 16'h0300; c[W-1:0] = 16'h0100;
        send({N{16'h0200}}, b, c, 1'b1, 1'b0);
        wait_drain(1, ok);
        total += 3;
        if (got_q.size() != 1) begin bad++; $display("FAIL basic_count got=%0d required=1", got_q.size()); end
        else begin
            if (got_q[0].d !== {N{16'h0500}}) begin bad++; $display("FAIL basic_value got=%h required=%h", got_q[0].d, {N{16'h0500}}); end
            if (got_q[0].t - exp_q[0].t != 3) begin bad++; $display("FAIL basic_latency got=%0d required=3", got_q[0].t - exp_q[0].t); end
        end
    endtask

    task automatic test_rounding;
        logic [NW-1:0] a, b, c;
        bit ok;
        exp_q.delete(); got_q.delete();
        a = rvec(); b = rvec(); c = rvec();
        a[15:0] = 16'h0001; b[15:0] = 16'h0080; c[15:0] = 16'h0000;
        a[31:16] = 16'hFFFF; b[31:16] = 16'h0080; c[31:16] = 16'h0000;
        send(a, b, c, 1'b0, 1'b0);
        wait_drain(1, ok);
        total += 3;
        if (got_q.size() != 1) begin bad++; $display("FAIL round_count got=%0d required=1", got_q.size()); end
        else begin
            if (got_q[0].d[15:0] !== 16'h0001) begin bad++; $display("FAIL round_tie_up got=%h required=0001", got_q[0].d[15:0]); end
            if (got_q[0].d[31:16] !== 16'h0000) begin bad++; $display("FAIL round_neg_tie got=%h required=0000", got_q[0].d[31:16]); end
            total++;
            if (got_q[0].d !== exp_q[0].d) begin bad++; $display("FAIL round_vector got=%h required=%h", got_q[0].d, exp_q[0].d); end
        end
    endtask

    task automatic test_saturation;
        logic [NW-1:0] a, b, c;
        bit ok;
        exp_q.delete(); got_q.delete();
        a = '0; b = '0; c = '0;
        a[15:0] = 16'h7FFF; b[15:0] = 16'h7FFF; c[15:0] = 16'h8000;
        a[31:16] = 16'h8000; b[31:16] = 16'h7FFF; c[31:16] = 16'h7FFF;
        send(a, b, c, 1'b0, 1'b0);
        wait_drain(1, ok);
        total += 3;
        if (got_q.size() != 1) begin bad++; $display("FAIL sat_count got=%0d required=1", got_q.size()); end
        else begin
            if (got_q[0].d[15:0] !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got=%h required=7fff", got_q[0].d[15:0]); end
            if (got_q[0].d[31:16] !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%h required=8000", got_q[0].d[31:16]); end
`ifdef VMS_SAT_FLAG_EN
            total++;
            if (got_q[0].s !== 8'b0000_0011) begin bad++; $display("FAIL sat_flags got=%b required=00000011", got_q[0].s); end
`endif
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [NW-1:0] held;
        exp_q.delete(); got_q.delete();
        fork
            for (int k = 0; k < 10; k++) send({N{16'(k * 16'h0100 + 16'h0010)}}, rvec(), rvec(), 1'b0, k == 9);
            begin
                wait (exp_q.size() >= 4);
                @(posedge clk); #1;
                out_ready = 0; held = out;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    total += 3;
                    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d got=%b required=0", k, in_ready); end
                    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold c%0d got=%b required=1", k, out_valid); end
                    if (out !== held) begin bad++; $display("FAIL bp_out_stable c%0d got=%h required=%h", k, out, held); end
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        wait_drain(10, ok);
        total++;
        if (got_q.size() != 10) begin bad++; $display("FAIL bp_count got=%0d required=10", got_q.size()); end
        for (int k = 0; k < 10 && k < got_q.size(); k++) begin
            total++;
            if (got_q[k].d !== exp_q[k].d || got_q[k].l !== exp_q[k].l)
                begin bad++; $display("FAIL bp_beat%0d got=%h/%b required=%h/%b", k, got_q[k].d, got_q[k].l, exp_q[k].d, exp_q[k].l); end
        end
    endtask

    task automatic test_last_mode;
        bit ok;
        exp_q.delete(); got_q.delete();
        for (int k = 0; k < 4; k++) send(rvec(), rvec(), rvec(), k % 2 == 0, k == 3);
        wait_drain(4, ok);
        total++;
        if (got_q.size() != 4) begin bad++; $display("FAIL lm_count got=%0d required=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            total += 2;
            if (got_q[k].d !== exp_q[k].d || got_q[k].s !== exp_q[k].s)
                begin bad++; $display("FAIL lm_value%0d got=%h required=%h", k, got_q[k].d, exp_q[k].d); end
            if (got_q[k].l !== (k == 3)) begin bad++; $display("FAIL lm_last%0d got=%b required=%b", k, got_q[k].l, k == 3); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        exp_q.delete(); got_q.delete();
        send(rvec(), rvec(), rvec(), 1'b0, 1'b0);
        send(rvec(), rvec(), rvec(), 1'b1, 1'b1);
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b required=0", out_valid); end
        exp_q.delete(); got_q.delete();
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL rm_ghost got=%0d required=0", got_q.size()); end
        send(rvec(), rvec(), rvec(), 1'b0, 1'b1);
        wait_drain(1, ok);
        total++;
        if (got_q.size() != 1) begin bad++; $display("FAIL rm_count got=%0d required=1", got_q.size()); end
        else begin
            total += 2;
            if (got_q[0].d !== exp_q[0].d) begin bad++; $display("FAIL rm_value got=%h required=%h", got_q[0].d, exp_q[0].d); end
            if (got_q[0].t - exp_q[0].t != 3) begin bad++; $display("FAIL rm_latency got=%0d required=3", got_q[0].t - exp_q[0].t); end
        end
    endtask

    task automatic test_random;
        bit ok, stop;
        exp_q.delete(); got_q.delete();
        stop = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    send(rvec(), rvec(), rvec(), 1'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #0;
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    out_ready = $urandom_range(0, 3) != 0;
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        wait_drain(40, ok);
        total++;
        if (got_q.size() != 40) begin bad++; $display("FAIL rnd_count got=%0d required=40", got_q.size()); end
        for (int k = 0; k < 40 && k < got_q.size(); k++) begin
            total++;
            if (got_q[k].d !== exp_q[k].d || got_q[k].l !== exp_q[k].l || got_q[k].s !== exp_q[k].s)
                begin bad++; $display("FAIL rnd_beat%0d got=%h/%b/%b required=%h/%b/%b", k, got_q[k].d, got_q[k].l, got_q[k].s, exp_q[k].d, exp_q[k].l, exp_q[k].s); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_last_mode();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
